// File: rtl/three_sort_stream.sv
// Streaming three-value sorter: collects three beats, sorts them with three
// registered compare-swap steps, then emits them largest-first with a last flag.
module three_sort_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] sets_done
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SORT    = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   step_q;
    logic [IDX_W-1:0]   beat_q;
    logic [WIDTH-1:0]   v0_q;
    logic [WIDTH-1:0]   v1_q;
    logic [WIDTH-1:0]   v2_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [CNT_W-1:0]   sets_done_q;

    // Compare-swap operands: step 1 works on (v1,v2), steps 0 and 2 on (v0,v1)
    logic [WIDTH-1:0]   cmp_a_c;
    logic [WIDTH-1:0]   cmp_b_c;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               swap_c;

    always_comb begin
        cmp_a_c = v0_q;
        cmp_b_c = v1_q;
        if (step_q == IDX_W'(1)) begin
            cmp_a_c = v1_q;
            cmp_b_c = v2_q;
        end
        // Strict less-than: equal values keep their positions
        swap_c = (cmp_a_c < cmp_b_c);
        hi_d   = swap_c ? cmp_b_c : cmp_a_c;
        lo_d   = swap_c ? cmp_a_c : cmp_b_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            step_q      <= '0;
            beat_q      <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sets_done_q <= '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        case (idx_q)
                            IDX_W'(0): v0_q <= in_data;
                            IDX_W'(1): v1_q <= in_data;
                            default:   v2_q <= in_data;
                        endcase
                        if (idx_q == IDX_W'(2)) begin
                            idx_q   <= '0;
                            step_q  <= '0;
                            state_q <= ST_SORT;
                        end else begin
                            idx_q <= IDX_W'(idx_q + IDX_W'(1));
                        end
                    end
                end

                ST_SORT: begin
                    if (step_q == IDX_W'(1)) begin
                        v1_q <= hi_d;
                        v2_q <= lo_d;
                    end else begin
                        v0_q <= hi_d;
                        v1_q <= lo_d;
                    end
                    if (step_q == IDX_W'(2)) begin
                        step_q  <= '0;
                        beat_q  <= '0;
                        state_q <= ST_EMIT;
                    end else begin
                        step_q <= IDX_W'(step_q + IDX_W'(1));
                    end
                end

                ST_EMIT: begin
                    // First EMIT cycle loads the maximum; later ones advance on accept
                    if (!out_valid_q) begin
                        out_data_q  <= v0_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        beat_q      <= '0;
                    end else if (out_ready) begin
                        case (beat_q)
                            IDX_W'(0): begin
                                out_data_q <= v1_q;
                                beat_q     <= IDX_W'(1);
                            end
                            IDX_W'(1): begin
                                out_data_q <= v2_q;
                                out_last_q <= 1'b1;
                                beat_q     <= IDX_W'(2);
                            end
                            default: begin
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                beat_q      <= '0;
                                sets_done_q <= CNT_W'(sets_done_q + CNT_W'(1));
                                state_q     <= ST_COLLECT;
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= ST_COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_COLLECT) && !rst;
    assign busy      = (state_q == ST_SORT) || (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sets_done = sets_done_q;

endmodule
